// File: rtl/alu_if_pkg.sv
// ---------------------------------------------------------------------------
// alu_if_pkg
// Shared definitions for the UART command responder and its ALU:
//   - default data / opcode widths and the default inter-byte timeout
//   - the eight ALU opcodes
//   - the responder FSM state encoding and a helper that flags busy states
// Optional feature macro used by the top: ALU_IF_TIMEOUT_EN
// ---------------------------------------------------------------------------
package alu_if_pkg;

  localparam int SIZEDATA_DEFAULT       = 8;
  localparam int SIZEOP_DEFAULT         = 6;
  localparam int TIMEOUT_CYCLES_DEFAULT = 2_000_000;

  localparam logic [5:0] OPC_ADD = 6'b100000;
  localparam logic [5:0] OPC_SUB = 6'b100010;
  localparam logic [5:0] OPC_AND = 6'b100100;
  localparam logic [5:0] OPC_OR  = 6'b100101;
  localparam logic [5:0] OPC_XOR = 6'b100110;
  localparam logic [5:0] OPC_NOR = 6'b100111;
  localparam logic [5:0] OPC_SRA = 6'b000011;
  localparam logic [5:0] OPC_SRL = 6'b000010;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_WAIT_OP1 = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_OP2 = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_OPC = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC     = 3'd3;
  localparam logic [STATE_W-1:0] ST_SEND     = 3'd4;
  localparam logic [STATE_W-1:0] ST_WAIT_TX  = 3'd5;

  // The responder is busy from the moment a full command is held until the
  // transmitter reports completion.
  function automatic logic isBusyState(input logic [STATE_W-1:0] state);
    return (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/alu_uart_interface_alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational ALU used by alu_uart_interface.
// Ports:
//   op1_i     [SIZEDATA-1:0]  first operand (signed two's complement)
//   op2_i     [SIZEDATA-1:0]  second operand / unsigned shift amount
//   opcode_i  [SIZEOP-1:0]    operation select
//   result_o  [SIZEDATA-1:0]  result, wraps modulo 2^SIZEDATA
//   invalid_o                 high when opcode_i is not a known operation
// ---------------------------------------------------------------------------
module alu
  import alu_if_pkg::*;
#(
  parameter int SIZEDATA = SIZEDATA_DEFAULT,
  parameter int SIZEOP   = SIZEOP_DEFAULT
) (
  input  logic [SIZEDATA-1:0] op1_i,
  input  logic [SIZEDATA-1:0] op2_i,
  input  logic [SIZEOP-1:0]   opcode_i,
  output logic [SIZEDATA-1:0] result_o,
  output logic                invalid_o
);

  logic shiftSaturates;

  // Shift amounts of a full word or more collapse to the fill value rather
  // than relying on the simulator/synthesis treatment of oversized shifts.
  assign shiftSaturates = (op2_i >= SIZEDATA'(SIZEDATA));

  // Operation decode; unknown opcodes yield zero and raise the invalid flag.
  always_comb begin
    result_o  = '0;
    invalid_o = 1'b0;
    case (opcode_i)
      SIZEOP'(OPC_ADD): result_o = op1_i + op2_i;
      SIZEOP'(OPC_SUB): result_o = op1_i - op2_i;
      SIZEOP'(OPC_AND): result_o = op1_i & op2_i;
      SIZEOP'(OPC_OR):  result_o = op1_i | op2_i;
      SIZEOP'(OPC_XOR): result_o = op1_i ^ op2_i;
      SIZEOP'(OPC_NOR): result_o = ~(op1_i | op2_i);
      SIZEOP'(OPC_SRA): begin
        if (shiftSaturates) begin
          result_o = {SIZEDATA{op1_i[SIZEDATA-1]}};
        end else begin
          result_o = $signed(op1_i) >>> op2_i;
        end
      end
      SIZEOP'(OPC_SRL): begin
        if (shiftSaturates) begin
          result_o = '0;
        end else begin
          result_o = op1_i >> op2_i;
        end
      end
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_uart_interface.sv
// ---------------------------------------------------------------------------
// alu_uart_interface
// Command responder between the UART core and an internal ALU. Collects
// operand 1, operand 2 and opcode bytes from the receiver, executes the
// operation, pulses the transmitter with the result and waits for transmit
// completion before accepting the next command.
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      synchronous active-low reset
//   i_rx_done    receiver byte-complete flag (edge-detected here)
//   i_rx_data    received byte, valid when i_rx_done rises
//   i_tx_done    transmitter done flag (edge-detected here)
//   o_tx_signal  one-cycle transmit start pulse
//   o_tx_result  byte to transmit, held until the next command executes
//   o_busy       high while executing, sending or waiting for the transmitter
//   o_error      sticky invalid-opcode flag, cleared on operand-1 capture
// Optional feature: define ALU_IF_TIMEOUT_EN to drop a partial command when
// no byte arrives for TIMEOUT_CYCLES clocks while waiting for operand 2 or
// the opcode.
// ---------------------------------------------------------------------------
module alu_uart_interface
  import alu_if_pkg::*;
#(
  parameter int SIZEDATA       = SIZEDATA_DEFAULT,
  parameter int SIZEOP         = SIZEOP_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_rx_done,
  input  logic [SIZEDATA-1:0] i_rx_data,
  input  logic                i_tx_done,
  output logic                o_tx_signal,
  output logic [SIZEDATA-1:0] o_tx_result,
  output logic                o_busy,
  output logic                o_error
);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [SIZEDATA-1:0] op1_q, op1_d;
  logic [SIZEDATA-1:0] op2_q, op2_d;
  logic [SIZEOP-1:0]   opcode_q, opcode_d;
  logic [SIZEDATA-1:0] txResult_q, txResult_d;
  logic                error_q, error_d;
  logic                rxDonePrev_q;
  logic                txDonePrev_q;

  logic                rxAccept;
  logic                txRise;
  logic                timeoutHit;
  logic [SIZEDATA-1:0] aluResult;
  logic                aluInvalid;

  // Bytes and transmit completions are recognised on the rising edge of the
  // UART flags, so a flag held high for several cycles counts once.
  assign rxAccept = i_rx_done & ~rxDonePrev_q;
  assign txRise   = i_tx_done & ~txDonePrev_q;

  alu #(
    .SIZEDATA (SIZEDATA),
    .SIZEOP   (SIZEOP)
  ) u_alu (
    .op1_i     (op1_q),
    .op2_i     (op2_q),
    .opcode_i  (opcode_q),
    .result_o  (aluResult),
    .invalid_o (aluInvalid)
  );

`ifdef ALU_IF_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;
  logic             counting;

  assign counting   = (state_q == ST_WAIT_OP2) || (state_q == ST_WAIT_OPC);
  assign timeoutHit = counting && !rxAccept && (timeoutCnt_q == CNT_LAST);

  // Idle counter for a partially received command: it restarts on every
  // accepted byte and rests at zero outside the operand-2/opcode wait.
  always_comb begin
    timeoutCnt_d = '0;
    if (counting && !rxAccept && !timeoutHit) begin
      timeoutCnt_d = timeoutCnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      timeoutCnt_q <= '0;
    end else begin
      timeoutCnt_q <= timeoutCnt_d;
    end
  end
`else
  assign timeoutHit = 1'b0;
`endif

  // Command sequencing. Bytes arriving while busy fall through the case
  // without effect, which discards them.
  always_comb begin
    state_d    = state_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    opcode_d   = opcode_q;
    txResult_d = txResult_q;
    error_d    = error_q;
    case (state_q)
      ST_WAIT_OP1: begin
        if (rxAccept) begin
          op1_d   = i_rx_data;
          error_d = 1'b0;
          state_d = ST_WAIT_OP2;
        end
      end
      ST_WAIT_OP2: begin
        if (rxAccept) begin
          op2_d   = i_rx_data;
          state_d = ST_WAIT_OPC;
        end else if (timeoutHit) begin
          state_d = ST_WAIT_OP1;
        end
      end
      ST_WAIT_OPC: begin
        if (rxAccept) begin
          opcode_d = i_rx_data[SIZEOP-1:0];
          state_d  = ST_EXEC;
        end else if (timeoutHit) begin
          state_d = ST_WAIT_OP1;
        end
      end
      ST_EXEC: begin
        txResult_d = aluResult;
        if (aluInvalid) begin
          error_d = 1'b1;
        end
        state_d = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (txRise) begin
          state_d = ST_WAIT_OP1;
        end
      end
      default: begin
        state_d = ST_WAIT_OP1;
      end
    endcase
  end

  // State, data and edge-detect registers; reset wins over any event.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q      <= ST_WAIT_OP1;
      op1_q        <= '0;
      op2_q        <= '0;
      opcode_q     <= '0;
      txResult_q   <= '0;
      error_q      <= 1'b0;
      rxDonePrev_q <= 1'b0;
      txDonePrev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      opcode_q     <= opcode_d;
      txResult_q   <= txResult_d;
      error_q      <= error_d;
      rxDonePrev_q <= i_rx_done;
      txDonePrev_q <= i_tx_done;
    end
  end

  assign o_tx_signal = (state_q == ST_SEND);
  assign o_tx_result = txResult_q;
  assign o_busy      = isBusyState(state_q);
  assign o_error     = error_q;

endmodule
